// File: rtl/viterbi_dec.sv
// Hard-decision Viterbi decoder for a fixed 4-state rate-1/2 code.
// Register-exchange survivors, serial c1/c0 input framing, and flush of the held tail when the stream ends.
module viterbi_dec #(
  parameter int TB_DEPTH = 16,
  parameter int PM_W     = 5
) (
  input  logic clk,
  input  logic rst_n,
  input  logic dec_en,
  input  logic din,
  output logic dout,
  output logic dout_valid,
  output logic busy
);

  localparam int CW = $clog2(TB_DEPTH + 1);
  localparam int IW = $clog2(TB_DEPTH);
  localparam logic [CW-1:0]   TB_CNT    = CW'(TB_DEPTH);
  localparam logic [CW-1:0]   TB_CNT_M1 = CW'(TB_DEPTH - 1);
  localparam logic [PM_W-1:0] PM_INIT   = PM_W'(4);
  localparam logic [PM_W:0]   PM_SAT    = {1'b0, {PM_W{1'b1}}};

  // Trellis seen from each destination state (s3 in the top slot); *_LO is the lower-numbered predecessor.
  localparam logic [7:0] PRED_LO = {2'd1, 2'd1, 2'd0, 2'd0};
  localparam logic [7:0] PRED_HI = {2'd3, 2'd3, 2'd2, 2'd2};
  localparam logic [7:0] LBL_LO  = {2'b01, 2'b10, 2'b11, 2'b00};
  localparam logic [7:0] LBL_HI  = {2'b10, 2'b01, 2'b00, 2'b11};
  localparam logic [3:0] X_LO    = {1'b0, 1'b1, 1'b1, 1'b0};
  localparam logic [3:0] X_HI    = {1'b1, 1'b0, 1'b0, 1'b1};

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FLUSH = 2'd2
  } state_t;

  state_t              state_q;
  logic [PM_W-1:0]     pm_q   [4];
  logic [TB_DEPTH-1:0] surv_q [4];
  logic [CW-1:0]       cnt_q;
  logic [CW-1:0]       pend_q;
  logic [TB_DEPTH-1:0] flush_sv_q;
  logic                phase_q;
  logic                c1_q;
  logic                emit_q;
  logic                dout_q;
  logic                dout_valid_q;
  logic                busy_q;

  logic [PM_W-1:0]     pm_d   [4];
  logic [TB_DEPTH-1:0] surv_d [4];
  logic [CW-1:0]       cnt_d;
  logic [PM_W:0]       pm_raw_s [4];
  logic [PM_W:0]       pm_min_s;
  logic [PM_W:0]       sum_lo_s;
  logic [PM_W:0]       sum_hi_s;
  logic [PM_W:0]       norm_s;
  logic [1:0]          sym_s;
  logic [1:0]          best_s;
  logic [IW-1:0]       pend_idx_s;
  logic                flush_bit_s;

  function automatic logic [1:0] branch_metric(input logic [1:0] rx, input logic [1:0] lbl);
    logic [1:0] diff;
    diff = rx ^ lbl;
    return {1'b0, diff[1]} + {1'b0, diff[0]};
  endfunction

  // Add-compare-select with normalisation; the lower-numbered predecessor wins a tie.
  always_comb begin
    sym_s    = {c1_q, din};
    sum_lo_s = '0;
    sum_hi_s = '0;
    norm_s   = '0;
    for (int s = 0; s < 4; s++) begin
      pm_raw_s[s] = '0;
      surv_d[s]   = '0;
      pm_d[s]     = '0;
    end
    for (int s = 0; s < 4; s++) begin
      sum_lo_s = {1'b0, pm_q[PRED_LO[2*s +: 2]]}
               + {{(PM_W-1){1'b0}}, branch_metric(sym_s, LBL_LO[2*s +: 2])};
      sum_hi_s = {1'b0, pm_q[PRED_HI[2*s +: 2]]}
               + {{(PM_W-1){1'b0}}, branch_metric(sym_s, LBL_HI[2*s +: 2])};
      if (sum_lo_s <= sum_hi_s) begin
        pm_raw_s[s] = sum_lo_s;
        surv_d[s]   = {surv_q[PRED_LO[2*s +: 2]][TB_DEPTH-2:0], X_LO[s]};
      end else begin
        pm_raw_s[s] = sum_hi_s;
        surv_d[s]   = {surv_q[PRED_HI[2*s +: 2]][TB_DEPTH-2:0], X_HI[s]};
      end
    end
    pm_min_s = pm_raw_s[0];
    for (int s = 1; s < 4; s++) begin
      if (pm_raw_s[s] < pm_min_s) begin
        pm_min_s = pm_raw_s[s];
      end else begin
        pm_min_s = pm_min_s;
      end
    end
    for (int s = 0; s < 4; s++) begin
      norm_s = pm_raw_s[s] - pm_min_s;
      if (norm_s > PM_SAT) begin
        pm_d[s] = {PM_W{1'b1}};
      end else begin
        pm_d[s] = norm_s[PM_W-1:0];
      end
    end
  end

  // Best current state (lowest number on a tie), saturating symbol count and flush bit select.
  always_comb begin
    best_s = 2'd0;
    for (int s = 1; s < 4; s++) begin
      if (pm_q[s] < pm_q[best_s]) begin
        best_s = 2'(s);
      end else begin
        best_s = best_s;
      end
    end
    if (cnt_q == TB_CNT) begin
      cnt_d = TB_CNT;
    end else begin
      cnt_d = cnt_q + CW'(1);
    end
    pend_idx_s  = IW'(pend_q - CW'(1));
    flush_bit_s = flush_sv_q[pend_idx_s];
  end

  // Control FSM with decoder state and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      pend_q       <= '0;
      flush_sv_q   <= '0;
      phase_q      <= 1'b0;
      c1_q         <= 1'b0;
      emit_q       <= 1'b0;
      dout_q       <= 1'b0;
      dout_valid_q <= 1'b0;
      busy_q       <= 1'b0;
      for (int s = 0; s < 4; s++) begin
        pm_q[s]   <= '0;
        surv_q[s] <= '0;
      end
    end else begin
      case (state_q)
        ST_IDLE: begin
          dout_valid_q <= 1'b0;
          emit_q       <= 1'b0;
          if (dec_en) begin
            state_q <= ST_RUN;
            busy_q  <= 1'b1;
            cnt_q   <= '0;
            c1_q    <= din;
            phase_q <= 1'b1;
            pm_q[0] <= '0;
            for (int s = 1; s < 4; s++) begin
              pm_q[s] <= PM_INIT;
            end
            for (int s = 0; s < 4; s++) begin
              surv_q[s] <= '0;
            end
          end else begin
            busy_q <= 1'b0;
          end
        end
        ST_RUN: begin
          dout_valid_q <= emit_q;
          emit_q       <= 1'b0;
          if (emit_q) begin
            dout_q <= surv_q[best_s][TB_DEPTH-1];
          end else begin
            dout_q <= dout_q;
          end
          if (!dec_en) begin
            // A dangling c1 is simply dropped here.
            state_q    <= ST_FLUSH;
            phase_q    <= 1'b0;
            flush_sv_q <= surv_q[best_s];
            pend_q     <= (cnt_q < TB_CNT) ? cnt_q : TB_CNT_M1;
          end else if (!phase_q) begin
            c1_q    <= din;
            phase_q <= 1'b1;
          end else begin
            phase_q <= 1'b0;
            pm_q    <= pm_d;
            surv_q  <= surv_d;
            cnt_q   <= cnt_d;
            emit_q  <= (cnt_d == TB_CNT);
          end
        end
        ST_FLUSH: begin
          if (pend_q == '0) begin
            state_q      <= ST_IDLE;
            busy_q       <= 1'b0;
            dout_valid_q <= 1'b0;
          end else begin
            dout_q       <= flush_bit_s;
            dout_valid_q <= 1'b1;
            pend_q       <= pend_q - CW'(1);
          end
        end
        default: begin
          state_q      <= ST_IDLE;
          busy_q       <= 1'b0;
          dout_valid_q <= 1'b0;
          emit_q       <= 1'b0;
        end
      endcase
    end
  end

  assign dout       = dout_q;
  assign dout_valid = dout_valid_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_viterbi_dec.sv
// Scoreboard bench for viterbi_dec: messages are encoded with the code table, and the
// message bits themselves are the expected decoder output.
module tb_viterbi_dec;

  localparam int TB = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic dec_en = 1'b0;
  logic din = 1'b0;
  logic dout;
  logic dout_valid;
  logic busy;

  viterbi_dec #(.TB_DEPTH(TB), .PM_W(5)) dut (
    .clk(clk), .rst_n(rst_n), .dec_en(dec_en), .din(din),
    .dout(dout), .dout_valid(dout_valid), .busy(busy)
  );

  always #5 clk = ~clk;

  // Encoder table: next state and c1c0 word for (state, x).
  int nxt_tab [4][2] = '{'{0, 1}, '{3, 2}, '{1, 0}, '{2, 3}};
  int out_tab [4][2] = '{'{0, 3}, '{1, 2}, '{0, 3}, '{1, 2}};

  int   cyc = 0;
  int   total = 0;
  int   bad = 0;
  int   pulses = 0;
  int   first_cyc = -1;
  int   last_cyc = -1;
  logic last_dout = 1'b0;
  bit   exp_q[$];
  bit   msg [0:127];

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: every dout_valid pulse pops one expected bit; dout must hold between pulses.
  always @(negedge clk) begin
    if (!rst_n) begin
      last_dout = 1'b0;
    end else if (dout_valid) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL unexpected_pulse dout=%0b required no pulse (cyc %0d)", dout, cyc);
      end else begin
        bit e;
        e = exp_q.pop_front();
        if (dout !== e) begin
          bad++;
          $display("FAIL dout got=%0b exp=%0b (cyc %0d)", dout, e, cyc);
        end
      end
      total++;
      if (busy !== 1'b1) begin
        bad++;
        $display("FAIL busy_in_pulse got=%0b exp=1 (cyc %0d)", busy, cyc);
      end
      pulses++;
      if (first_cyc < 0) first_cyc = cyc;
      last_cyc  = cyc;
      last_dout = dout;
    end else begin
      total++;
      if (dout !== last_dout) begin
        bad++;
        $display("FAIL dout_hold got=%0b exp=%0b (cyc %0d)", dout, last_dout, cyc);
      end
    end
  end

  task automatic chk(input string name, input int got, input int exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", name, got, exp);
    end
  endtask

  task automatic rand_msg(input int n);
    for (int i = 0; i < n; i++) msg[i] = 1'($urandom_range(0, 1));
  endtask

  task automatic run_burst(input int nsym, input bit odd, input int err_pos);
    bit code[$];
    int st;
    int c;
    int start_cyc;
    int fall_cyc;
    st = 0;
    for (int i = 0; i < nsym; i++) begin
      c = out_tab[st][msg[i]];
      code.push_back(1'((c >> 1) & 1));
      code.push_back(1'(c & 1));
      st = nxt_tab[st][msg[i]];
      exp_q.push_back(msg[i]);
    end
    if (odd) code.push_back(1'($urandom_range(0, 1)));
    if (err_pos >= 0) code[err_pos] = ~code[err_pos];
    pulses = 0;
    first_cyc = -1;
    last_cyc = -1;
    @(posedge clk); #1;
    start_cyc = cyc;
    dec_en = 1'b1;
    din = code[0];
    for (int i = 1; i < code.size(); i++) begin
      @(posedge clk); #1;
      din = code[i];
    end
    @(posedge clk); #1;
    dec_en = 1'b0;
    din = 1'($urandom_range(0, 1));
    fall_cyc = -1;
    for (int t = 0; t < 4 * TB + 20; t++) begin
      @(negedge clk);
      if (!busy) begin
        fall_cyc = cyc;
        break;
      end
    end
    if (fall_cyc < 0) begin
      total++;
      bad++;
      $display("FAIL busy_timeout got=busy stuck high exp=busy low");
    end else if (nsym > 0) begin
      chk("busy_fall_after_last", fall_cyc - last_cyc, 1);
    end
    chk("drain", exp_q.size(), 0);
    chk("pulse_count", pulses, nsym);
    if (nsym >= TB) chk("first_latency", first_cyc - start_cyc, 2 * TB + 1);
    exp_q.delete();
    repeat (3) @(posedge clk);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

  initial begin
    bit code10[$];
    int st;
    int c;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_dout", dout, 0);
    chk("reset_valid", dout_valid, 0);
    chk("reset_busy", busy, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (2) @(posedge clk);

    // All-zero stream, 20 symbols.
    for (int i = 0; i < 20; i++) msg[i] = 1'b0;
    run_burst(20, 1'b0, -1);

    // Impulse, then the same stream with the 4th code bit inverted.
    msg[0] = 1'b1;
    run_burst(20, 1'b0, -1);
    run_burst(20, 1'b0, 3);

    // Random 20-symbol flush test and odd 7-bit stream.
    rand_msg(20);
    run_burst(20, 1'b0, -1);
    rand_msg(3);
    run_burst(3, 1'b1, -1);

    // Reset mid-run at symbol 10.
    rand_msg(10);
    st = 0;
    for (int i = 0; i < 10; i++) begin
      c = out_tab[st][msg[i]];
      code10.push_back(1'((c >> 1) & 1));
      code10.push_back(1'(c & 1));
      st = nxt_tab[st][msg[i]];
    end
    @(posedge clk); #1;
    dec_en = 1'b1;
    din = code10[0];
    for (int i = 1; i < 20; i++) begin
      @(posedge clk); #1;
      din = code10[i];
    end
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    chk("midrun_reset_valid", dout_valid, 0);
    chk("midrun_reset_busy", busy, 0);
    chk("midrun_reset_dout", dout, 0);
    dec_en = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    chk("post_reset_busy", busy, 0);
    rand_msg(20);
    run_burst(20, 1'b0, -1);

    // Random bursts, including lengths either side of the traceback depth and long saturating runs.
    for (int r = 0; r < 24; r++) begin
      int n;
      n = $urandom_range(1, 40);
      rand_msg(n);
      run_burst(n, 1'($urandom_range(0, 1)), -1);
    end
    rand_msg(70);
    run_burst(70, 1'b1, -1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/viterbi_dec.md
VITERBI_DEC -- requirements
Module: viterbi_dec

Interface
REQ-001 Parameter TB_DEPTH, 16, survivor register length in symbols; legal range 8..32.
REQ-002 Parameter PM_W, 5, path-metric width in bits.
REQ-003 clk  input  1  single system clock; all state changes on its rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 dec_en  input  1  high = serial code stream present on din.
REQ-006 din  input  1  hard-decision code bit, one per clk while dec_en high.
REQ-007 dout  output  1  decoded information bit.
REQ-008 dout_valid  output  1  one-cycle qualifier for dout.
REQ-009 busy  output  1  high in RUN or FLUSH.

Function
REQ-010 Decodes the rate-1/2, 4-state code (states s0..s3) whose trellis is fixed. Each entry is "state, input x -> next state, output c1c0":
- s0,0->s0,00
- s0,1->s1,11
- s1,0->s3,01
- s1,1->s2,10
- s2,0->s1,00
- s2,1->s0,11
- s3,0->s2,01
- s3,1->s3,10
REQ-011 Serial symbol framing: the first din sampled in a pair is c1, the second is c0; pair phase clears to "first" on entering RUN.
REQ-012 FSM states IDLE, RUN, FLUSH.
- IDLE->RUN when dec_en=1 (the din of that edge is c1 of symbol 1).
- RUN->FLUSH when dec_en=0.
- FLUSH->IDLE when the pending count reaches 0, or immediately if it is 0 on entry.
REQ-013 Branch metric = Hamming distance (0..2) between the received {c1,c0} and the branch label.
REQ-014 ACS occurs on the edge sampling c0. For each state, new PM = min over its two predecessors of (PM + BM). On a tie, the lower-numbered predecessor wins.
REQ-015 Normalisation: after ACS, subtract the minimum new PM from all four; PMs never wrap.
REQ-016 Register exchange: new survivor = {chosen predecessor's survivor[TB_DEPTH-2:0], x of that branch}.
REQ-017 On entering RUN:
- PM(s0)=0, PM(s1..s3)=4.
- All survivors = 0.
- Symbol count = 0.
REQ-018 Symbol count saturates at TB_DEPTH.
REQ-019 In RUN, when the count (after increment) equals TB_DEPTH, the next cycle drives:
- dout = survivor[TB_DEPTH-1] of the minimum-PM state (tie: lowest state number);
- dout_valid=1.
REQ-020 Decode latency: the bit for symbol n is output 1 cycle after the ACS of symbol n+TB_DEPTH-1.
REQ-021 On FLUSH entry, latch the minimum-PM state and its survivor. Pending = count if count<TB_DEPTH, else TB_DEPTH-1.
REQ-022 In FLUSH, output one bit per cycle, oldest first: survivor bit pending-1 down to 0, with dout_valid=1, decrementing pending.
REQ-023 A half-received symbol (odd bit count) at dec_en fall is discarded; no ACS occurs for it.
REQ-024 din and dec_en are ignored in FLUSH. A dec_en still high when FLUSH ends causes IDLE->RUN on the following edge.
REQ-025 Total dout_valid pulses per burst = number of complete symbols received.
REQ-026 dout holds its last value when dout_valid=0.

Reset
REQ-027 rst_n low, asynchronously and at any point including mid-RUN or mid-FLUSH:
- FSM=IDLE;
- dout=0, dout_valid=0, busy=0;
- PMs, survivors, counts and pair phase cleared;
- no pending bits survive.
REQ-028 Operation resumes on the first rising edge after rst_n deasserts, per REQ-012.

Verification
REQ-029 All-zero stream: 40 din=0 cycles then dec_en low -> exactly 20 dout_valid pulses, all dout=0. The first pulse comes 1 cycle after the 16th symbol.
REQ-030 Impulse: message 1,0,0,... (20 bits) encoded as 11 01 01 00 01 01 00 ... -> dout sequence 1 followed by 19 zeros.
REQ-031 Single error: REQ-030 stream with the 4th code bit inverted -> identical dout sequence, no extra or missing pulses.
REQ-032 Flush: 20 random message bits encoded and streamed, then dec_en low -> 5 bits in RUN plus 15 bits in FLUSH, equal to the message in order; busy falls after the last pulse.
REQ-033 Odd length: 7 din bits then dec_en low -> 3 pulses (FLUSH only), matching the first 3 message bits.
REQ-034 Reset mid-run: rst_n low for 1 cycle at symbol 10 -> dout_valid=0 immediately, busy=0. A new 20-symbol burst then decodes correctly from the REQ-017 initial state.
